mem_io_bridge: RTL and testbench
================================

MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 Parameters SHALL be the following, one per line.
- DATA_W, 32, CPU data/address width.
- IO_W, 16, width of one LED or switch channel.
- N_LED, 2, number of LED channels.
- N_SW, 2, number of switch channels.
- MEM_LAT, 1, data-memory read latency in cycles; SHALL be at least 1.
- SW_SEXT, 0, 1 = sign-extend switch data, 0 = zero-extend.
REQ-002 Ports SHALL be the following, one per line.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  CPU access request this cycle.
- mem_read / mem_write / io_read / io_write  in  1 each  access type from controller.
- addr_in  in  DATA_W  address from ALU.
- r_rdata  in  DATA_W  store data from register file.
- stall  out  1  CPU must hold the request and the pipeline.
- r_wdata  out  DATA_W  load result to register file.
- r_wvalid  out  1  one-cycle strobe qualifying r_wdata.
- m_addr  out  DATA_W  data-memory address.
- m_wdata  out  DATA_W  data-memory write data.
- m_we  out  1  data-memory write enable.
- m_rdata  in  DATA_W  data-memory read data.
- led_out  out  N_LED*IO_W  registered LED channels; channel k at bits [k*IO_W +: IO_W].
- sw_in  in  N_SW*IO_W  raw asynchronous switch channels.
- err  out  1  one-cycle strobe on an illegal access.

Function
REQ-003 IO decode SHALL be as follows.
- addr_in[7:4] = 4'h6 selects LED channel addr_in[3:2].
- addr_in[7:4] = 4'h7 selects switch channel addr_in[3:2].
- A channel index at or above N_LED / N_SW is unmapped.
REQ-004 The FSM SHALL have three states: IDLE, M_WAIT, RESP. Requests are accepted only in IDLE.
REQ-005 Legal request: req_valid=1 with exactly one of the four type flags set. Otherwise, in IDLE, there SHALL be no side effect and err=1 for one cycle.
REQ-006 Memory write accepted in cycle N SHALL behave as follows.
- m_we=1 combinationally in cycle N only, with m_addr=addr_in and m_wdata=r_rdata.
- stall=0; state stays IDLE.
REQ-007 IO write accepted in cycle N SHALL behave as follows.
- The selected LED channel loads r_rdata[IO_W-1:0] at the end of cycle N; visible on led_out from N+1.
- stall=0.
REQ-008 Memory read accepted in cycle N SHALL behave as follows.
- m_addr=addr_in in cycle N; the address is latched and held on m_addr through M_WAIT.
- IDLE->M_WAIT; a counter counts to MEM_LAT.
- m_rdata is captured at the end of cycle N+MEM_LAT; state -> RESP.
- r_wvalid=1 in cycle N+MEM_LAT+1 with r_wdata = captured value; RESP->IDLE.
- stall=1 in cycles N .. N+MEM_LAT.
REQ-009 IO read accepted in cycle N SHALL behave as follows.
- The selected synchronised switch channel is captured at the end of cycle N, extended per SW_SEXT to DATA_W.
- IDLE->RESP; r_wvalid=1 in cycle N+1; stall=1 in cycle N only.
REQ-010 Unmapped IO accesses SHALL behave as follows.
- Unmapped IO read: completes as REQ-009 with r_wdata=0 and err=1 in cycle N.
- Unmapped IO write: no LED change, err=1 in cycle N.
REQ-011 Switch inputs SHALL pass through a two-flop synchroniser per bit; reads return the second stage.
REQ-012 r_wdata SHALL hold its last value when r_wvalid=0; it is never high-impedance.
REQ-013 req_valid in M_WAIT or RESP SHALL be ignored (the CPU is stalled), with no err.
REQ-014 Counter width SHALL be $clog2(MEM_LAT+1); the counter wraps only via reset to 0 on entering M_WAIT.

Reset
REQ-015 rst=1 SHALL asynchronously force the following.
- state=IDLE, counter=0.
- led_out=0, r_wdata=0, r_wvalid=0, err=0.
- Synchroniser flops = 0.
- Combinational outputs follow from IDLE: stall=0 and m_we=0 while rst is high.
REQ-016 Reset during M_WAIT or RESP SHALL abort the read with no r_wvalid; the first legal request after rst falls is accepted normally.

Structure
REQ-017 The shared package mem_io_pkg SHALL hold the state enum, IO nibble constants 4'h6/4'h7 and channel-field position [3:2].
REQ-018 The switch synchroniser SHALL be the sub-module sync2 (parameter W), instantiated once over all N_SW*IO_W bits.

Verification
REQ-019 The bench SHALL cover these directed scenarios.
- IO write: addr 0x64, r_rdata 0x0000_A5A5 -> led_out[31:16]=16'hA5A5 next cycle, channel 0 unchanged, stall=0.
- Memory read: MEM_LAT=3, m_rdata=0xDEAD_BEEF -> stall high 4 cycles, r_wvalid one cycle at N+4 with 0xDEADBEEF.
- IO read: sw_in ch1=16'h8001 held 3 cycles, addr 0x74, SW_SEXT=1 -> r_wdata=0xFFFF_8001 at N+1; SW_SEXT=0 -> 0x0000_8001.
- Illegal request: mem_read and io_write both set -> err pulse, no m_we, led_out unchanged. Unmapped addr 0x6C with N_LED=2 -> err, no LED change.
- Reset mid-read: rst at N+1 of a MEM_LAT=3 read -> no r_wvalid, stall=0; next IO read completes at +1.
- Memory write: addr 0x100, r_rdata 0x1234 -> m_we=1 one cycle, m_addr=0x100, m_wdata=0x1234.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared types and IO address-map constants for the CPU memory/IO bridge.
package mem_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_M_WAIT = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] IO_LED_NIB = 4'h6;
  localparam logic [3:0] IO_SW_NIB  = 4'h7;
  localparam int         CH_MSB     = 3;
  localparam int         CH_LSB     = 2;

endpackage

// File: rtl/mem_io_bridge_sync2.sv
// Two-flop synchroniser for asynchronous level inputs; q is the second stage.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/mem_io_bridge.sv
// Bridges CPU load/store requests onto a fixed-latency data memory, LED
// output registers and synchronised switch inputs.
//
// state   | meaning
// IDLE    | accepting requests; writes complete here in one cycle
// M_WAIT  | memory read in flight, counting MEM_LAT cycles
// RESP    | r_wvalid strobe with the captured load data
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IO_W    = 16,
  parameter int N_LED   = 2,
  parameter int N_SW    = 2,
  parameter int MEM_LAT = 1,
  parameter int SW_SEXT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  io_read,
  input  logic                  io_write,
  input  logic [DATA_W-1:0]     addr_in,
  input  logic [DATA_W-1:0]     r_rdata,
  output logic                  stall,
  output logic [DATA_W-1:0]     r_wdata,
  output logic                  r_wvalid,
  output logic [DATA_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic                  m_we,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic [N_LED*IO_W-1:0] led_out,
  input  logic [N_SW*IO_W-1:0]  sw_in,
  output logic                  err
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int CH_W  = CH_MSB - CH_LSB + 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [DATA_W-1:0]       r_addr_lat;
  logic [N_LED*IO_W-1:0]   r_led;
  logic [N_SW*IO_W-1:0]    w_sw_sync;
  logic [IO_W-1:0]         w_sw_ch;
  logic [DATA_W-1:0]       w_sw_ext;
  logic [CH_W-1:0]         w_ch;
  logic [3:0]              w_nib;
  logic                    w_onehot;
  logic                    w_led_hit;
  logic                    w_sw_hit;
  logic                    w_legal;
  logic                    w_acc_mr;
  logic                    w_acc_ior;
  logic                    w_led_wr;

  sync2 #(.W(N_SW*IO_W)) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_in),
    .q   (w_sw_sync)
  );

  assign w_ch      = addr_in[CH_MSB:CH_LSB];
  assign w_nib     = addr_in[7:4];
  assign w_onehot  = $onehot({mem_read, mem_write, io_read, io_write});
  assign w_led_hit = (w_nib == IO_LED_NIB) && (int'(w_ch) < N_LED);
  assign w_sw_hit  = (w_nib == IO_SW_NIB) && (int'(w_ch) < N_SW);
  // Acceptance is masked while rst is high so no side effect leaks out of reset.
  assign w_legal   = (r_state == ST_IDLE) && !rst && req_valid && w_onehot;
  assign w_acc_mr  = w_legal && mem_read;
  assign w_acc_ior = w_legal && io_read;
  assign w_led_wr  = w_legal && io_write && w_led_hit;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  always_comb begin
    w_sw_ch = '0;
    for (int k = 0; k < N_SW; k++) begin
      if (int'(w_ch) == k) w_sw_ch = w_sw_sync[k*IO_W +: IO_W];
    end
  end

  assign w_sw_ext = (SW_SEXT != 0) ? {{(DATA_W-IO_W){w_sw_ch[IO_W-1]}}, w_sw_ch}
                                   : {{(DATA_W-IO_W){1'b0}}, w_sw_ch};

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    m_we        = 1'b0;
    err         = 1'b0;
    m_addr      = r_addr_lat;
    case (r_state)
      ST_IDLE: begin
        m_addr = addr_in;
        if (!rst && req_valid) begin
          if (!w_onehot) begin
            err = 1'b1;
          end else if (mem_write) begin
            m_we = 1'b1;
          end else if (mem_read) begin
            stall       = 1'b1;
            w_state_nxt = ST_M_WAIT;
          end else if (io_read) begin
            stall       = 1'b1;
            err         = !w_sw_hit;
            w_state_nxt = ST_RESP;
          end else begin
            err = !w_led_hit;
          end
        end
      end
      ST_M_WAIT: begin
        stall = 1'b1;
        if (w_cnt_nxt == CNT_W'(MEM_LAT)) w_state_nxt = ST_RESP;
      end
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr_lat <= '0;
      r_led      <= '0;
      r_wdata    <= '0;
      r_wvalid   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wvalid <= 1'b0;
      if (w_acc_mr) begin
        r_cnt      <= '0;
        r_addr_lat <= addr_in;
      end else if (r_state == ST_M_WAIT) begin
        r_cnt <= w_cnt_nxt;
      end
      if ((r_state == ST_M_WAIT) && (w_state_nxt == ST_RESP)) begin
        r_wdata  <= m_rdata;
        r_wvalid <= 1'b1;
      end
      if (w_acc_ior) begin
        r_wdata  <= w_sw_hit ? w_sw_ext : '0;
        r_wvalid <= 1'b1;
      end
      for (int k = 0; k < N_LED; k++) begin
        if (w_led_wr && (int'(w_ch) == k)) r_led[k*IO_W +: IO_W] <= r_rdata[IO_W-1:0];
      end
    end
  end

  assign m_wdata = r_rdata;
  assign led_out = r_led;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: load results are scoreboarded through a
// queue, everything else is checked against bench-side constants.
module tb_mem_io_bridge;

  localparam int DW  = 32;
  localparam int IW  = 16;
  localparam int NL  = 2;
  localparam int NS  = 2;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, mem_read, mem_write, io_read, io_write;
  logic [DW-1:0] addr_in, r_rdata, m_rdata;
  logic [NS*IW-1:0] sw_in;

  logic          stall, r_wvalid, m_we, err;
  logic [DW-1:0] r_wdata, m_addr, m_wdata;
  logic [NL*IW-1:0] led_out;

  logic          z_stall, z_r_wvalid, z_m_we, z_err;
  logic [DW-1:0] z_r_wdata, z_m_addr, z_m_wdata;
  logic [NL*IW-1:0] z_led_out;

  int            n_vec  = 0;
  int            n_miss = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mem_io_bridge #(.DATA_W(DW), .IO_W(IW), .N_LED(NL), .N_SW(NS), .MEM_LAT(LAT), .SW_SEXT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
    .io_read(io_read), .io_write(io_write), .addr_in(addr_in), .r_rdata(r_rdata),
    .stall(stall), .r_wdata(r_wdata), .r_wvalid(r_wvalid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_we(m_we), .m_rdata(m_rdata), .led_out(led_out), .sw_in(sw_in), .err(err)
  );

  mem_io_bridge #(.DATA_W(DW), .IO_W(IW), .N_LED(NL), .N_SW(NS), .MEM_LAT(LAT), .SW_SEXT(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
    .io_read(io_read), .io_write(io_write), .addr_in(addr_in), .r_rdata(r_rdata),
    .stall(z_stall), .r_wdata(z_r_wdata), .r_wvalid(z_r_wvalid), .m_addr(z_m_addr), .m_wdata(z_m_wdata),
    .m_we(z_m_we), .m_rdata(m_rdata), .led_out(z_led_out), .sw_in(sw_in), .err(z_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    io_read   = 1'b0;
    io_write  = 1'b0;
    addr_in   = '0;
    r_rdata   = '0;
  endtask

  always @(negedge clk) begin
    if (r_wvalid === 1'b1) begin
      if (exp_q.size() == 0) chk("wvalid_unexpected", r_wvalid, 1'b0);
      else                   chk("r_wdata", r_wdata, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_in();
    m_rdata = '0;
    sw_in   = '0;

    // A store held during reset must not reach memory.
    @(negedge clk);
    req_valid = 1'b1; mem_write = 1'b1; addr_in = 32'h100; #1;
    chk("rst_m_we", m_we, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_led", led_out, 32'h0);
    chk("rst_wvalid", r_wvalid, 1'b0);
    chk("rst_wdata", r_wdata, 32'h0);
    idle_in();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    req_valid = 1'b1; io_write = 1'b1; addr_in = 32'h64; r_rdata = 32'h0000A5A5; #1;
    chk("iow_stall", stall, 1'b0);
    chk("iow_err", err, 1'b0);
    chk("iow_m_we", m_we, 1'b0);
    chk("iow_led_pre", led_out, 32'h0);
    @(negedge clk); idle_in(); #1;
    chk("iow_led_ch1", led_out, 32'hA5A5_0000);
    req_valid = 1'b1; io_write = 1'b1; addr_in = 32'h60; r_rdata = 32'hFFFF_5A5A; #1;
    chk("iow0_stall", stall, 1'b0);
    @(negedge clk); idle_in(); #1;
    chk("iow_led_ch0", led_out, 32'hA5A5_5A5A);

    req_valid = 1'b1; mem_write = 1'b1; addr_in = 32'h100; r_rdata = 32'h1234; #1;
    chk("mw_we", m_we, 1'b1);
    chk("mw_addr", m_addr, 32'h100);
    chk("mw_wdata", m_wdata, 32'h1234);
    chk("mw_stall", stall, 1'b0);
    @(negedge clk); idle_in(); #1;
    chk("mw_we_off", m_we, 1'b0);

    // Memory only presents the real word in the cycle the bridge must capture it.
    req_valid = 1'b1; mem_read = 1'b1; addr_in = 32'h200; m_rdata = 32'hBAD0_0000;
    exp_q.push_back(32'hDEAD_BEEF); #1;
    chk("mr_stall_0", stall, 1'b1);
    chk("mr_addr_0", m_addr, 32'h200);
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      m_rdata = (i == LAT) ? 32'hDEAD_BEEF : 32'hBAD0_0000 + i; #1;
      chk($sformatf("mr_stall_%0d", i), stall, 1'b1);
      chk("mr_addr_hold", m_addr, 32'h200);
      chk("mr_wvalid_early", r_wvalid, 1'b0);
    end
    @(negedge clk); m_rdata = 32'hBAD0_FFFF; #1;
    chk("mr_stall_resp", stall, 1'b0);
    chk("mr_wvalid", r_wvalid, 1'b1);
    chk("mr_err_held", err, 1'b0);
    @(negedge clk); idle_in(); #1;
    chk("mr_wvalid_off", r_wvalid, 1'b0);
    chk("mr_wdata_hold", r_wdata, 32'hDEAD_BEEF);

    sw_in = {16'h8001, 16'h0F0F};
    repeat (3) @(negedge clk);
    req_valid = 1'b1; io_read = 1'b1; addr_in = 32'h74;
    exp_q.push_back(32'hFFFF_8001); #1;
    chk("ior_stall", stall, 1'b1);
    chk("ior_err", err, 1'b0);
    @(negedge clk); idle_in(); #1;
    chk("ior_stall_off", stall, 1'b0);
    chk("ior_wvalid", r_wvalid, 1'b1);
    chk("ior_z_wvalid", z_r_wvalid, 1'b1);
    chk("ior_z_wdata", z_r_wdata, 32'h0000_8001);
    @(negedge clk);
    req_valid = 1'b1; io_read = 1'b1; addr_in = 32'h70;
    exp_q.push_back(32'h0000_0F0F);
    @(negedge clk); idle_in(); #1;
    chk("ior0_z_wdata", z_r_wdata, 32'h0000_0F0F);

    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; io_write = 1'b1; addr_in = 32'h64; r_rdata = 32'hFFFF; #1;
    chk("ill_err", err, 1'b1);
    chk("ill_m_we", m_we, 1'b0);
    chk("ill_stall", stall, 1'b0);
    @(negedge clk); idle_in(); #1;
    chk("ill_led", led_out, 32'hA5A5_5A5A);
    chk("ill_err_off", err, 1'b0);
    chk("ill_wvalid", r_wvalid, 1'b0);

    req_valid = 1'b1; io_write = 1'b1; addr_in = 32'h6C; r_rdata = 32'hFFFF; #1;
    chk("umw_err", err, 1'b1);
    @(negedge clk); idle_in(); #1;
    chk("umw_led", led_out, 32'hA5A5_5A5A);

    req_valid = 1'b1; io_read = 1'b1; addr_in = 32'h7C;
    exp_q.push_back(32'h0); #1;
    chk("umr_err", err, 1'b1);
    chk("umr_stall", stall, 1'b1);
    @(negedge clk); idle_in(); #1;
    chk("umr_wvalid", r_wvalid, 1'b1);

    // Abort a read in M_WAIT; no strobe may follow.
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; addr_in = 32'h300; m_rdata = 32'h1111_1111; #1;
    chk("rr_stall", stall, 1'b1);
    @(negedge clk); rst = 1'b1; #1;
    chk("rr_stall_rst", stall, 1'b0);
    chk("rr_wvalid_rst", r_wvalid, 1'b0);
    chk("rr_led_rst", led_out, 32'h0);
    @(negedge clk); rst = 1'b0; idle_in();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("rr_quiet", r_wvalid, 1'b0);
    end
    req_valid = 1'b1; io_read = 1'b1; addr_in = 32'h74;
    exp_q.push_back(32'hFFFF_8001); #1;
    chk("rr_ior_stall", stall, 1'b1);
    @(negedge clk); idle_in(); #1;
    chk("rr_ior_wvalid", r_wvalid, 1'b1);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
